// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit integer divider for the MIPS execute stage (DIV / DIVU).
// Radix-2 restoring core that produces one quotient bit per cycle. A divide takes 34 cycles:
// one IDLE cycle where the start is seen, 32 DIV cycles, then one DONE cycle that applies the
// signs and presents the result.
//
// Ports:
//   clk       pipeline clock; all state updates on the rising edge
//   resetn    synchronous, active-low reset
//   start_i   divide instruction present in E (held high while the pipeline is stalled)
//   signed_i  1 = DIV (two's complement), 0 = DIVU
//   a_i       dividend
//   b_i       divisor
//   annul_i   E flush/exception; cancels any operation in flight
//   stall_o   stall request to the hazard unit
//   ready_o   one-cycle pulse; result_o is valid for the instruction in E
//   result_o  {remainder, quotient}; holds its value until the next completed divide
//
// Optional feature (macro DIV_ZERO_FAST_EN): a zero divisor seen in IDLE goes straight to DONE.
// The result is bit-identical to the iterative path.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        annul_i,
  output logic        stall_o,
  output logic        ready_o,
  output logic [63:0] result_o
);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] dvd_q, dvd_d;    // dividend magnitude, shifted out MSB first
  logic [31:0] rem_q, rem_d;    // partial remainder
  logic [31:0] quo_q, quo_d;    // quotient magnitude
  logic [31:0] bmag_q, bmag_d;  // divisor magnitude
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;

  logic        go;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, trial;
  logic        borrow;
  logic [31:0] quo_fix, rem_fix;
`ifdef DIV_ZERO_FAST_EN
  logic        b_zero;
`endif

  always_comb begin
    go      = start_i & ~annul_i;
    a_neg   = signed_i & a_i[31];
    b_neg   = signed_i & b_i[31];
    a_mag   = a_neg ? (~a_i + 32'd1) : a_i;
    b_mag   = b_neg ? (~b_i + 32'd1) : b_i;
    shifted = {rem_q, dvd_q[31]};
    // rem_q < bmag_q always holds (rem_q < 2^31 for a zero divisor), so bit 32 is the borrow.
    trial   = shifted - {1'b0, bmag_q};
    borrow  = trial[32];
    quo_fix = qneg_q ? (~quo_q + 32'd1) : quo_q;
    rem_fix = rneg_q ? (~rem_q + 32'd1) : rem_q;
`ifdef DIV_ZERO_FAST_EN
    b_zero  = (b_i == 32'd0);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; annul overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = b_zero ? StDone : StDiv;
`else
          state_d = StDiv;
`endif
        end
      end
      StDiv:   if (cnt_q == 5'd31) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (annul_i) state_d = StIdle;
  end

  // Outputs. The new result is driven straight through in DONE so it lines up with ready_o.
  always_comb begin
    stall_o  = start_i & ~annul_i & (state_q != StDone);
    ready_o  = (state_q == StDone) & ~annul_i;
    result_o = ready_o ? {rem_fix, quo_fix} : result_q;
  end

  // Datapath next state.
  always_comb begin
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    bmag_d   = bmag_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          dvd_d  = a_mag;
          rem_d  = 32'd0;
          quo_d  = 32'd0;
          bmag_d = b_mag;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = 5'd0;
`ifdef DIV_ZERO_FAST_EN
          // Same magnitudes the iterative loop would reach with a zero divisor.
          if (b_zero) begin
            quo_d = 32'hFFFF_FFFF;
            rem_d = a_mag;
          end
`endif
        end
      end
      StDiv: begin
        dvd_d = {dvd_q[30:0], 1'b0};
        rem_d = borrow ? shifted[31:0] : trial[31:0];
        quo_d = {quo_q[30:0], ~borrow};
        cnt_d = cnt_q + 5'd1;
      end
      StDone: begin
        if (!annul_i) result_d = {rem_fix, quo_fix};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dvd_q    <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      bmag_q   <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= 5'd0;
      result_q <= 64'd0;
    end else begin
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      bmag_q   <= bmag_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule
